// File: rtl/homomorphic_multiply_stream.sv
// Streaming polynomial multiplier for ciphertext coefficient vectors.
// Two N-coefficient vectors arrive over a PARALLEL-lane valid/ready stream
// (A first, then B). The product mod 2^Q_WIDTH is computed PARALLEL output
// coefficients at a time, with N MAC cycles per output beat. Linear
// (2N-1 coefficients) or negacyclic mod x^N+1 (N coefficients) results leave
// on a backpressured PARALLEL-lane output stream.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous reset, active-high
//   mode_i       0 = linear, 1 = negacyclic; sampled with the first A beat
//   in_valid_i   input beat valid
//   in_ready_o   input beat can be accepted (LOAD_A / LOAD_B only)
//   in_data_i    lane p = coefficient beat*PARALLEL + p
//   out_valid_o  output beat valid
//   out_ready_i  downstream accepts output beat
//   out_data_o   lane p = result coefficient k + p (0 beyond the product)
//   out_last_o   final beat of the product
//   busy_o       an operation is in progress
module homomorphic_multiply_stream #(
    parameter int unsigned N         = 4,
    parameter int unsigned PARALLEL  = 2,
    parameter int unsigned Q_WIDTH   = 10,
    parameter int unsigned IDX_WIDTH = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          mode_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [PARALLEL*Q_WIDTH-1:0]   in_data_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [PARALLEL*Q_WIDTH-1:0]   out_data_o,
    output logic                          out_last_o,
    output logic                          busy_o
);

    localparam int unsigned BEATS = N / PARALLEL;
    localparam int unsigned AW    = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned DW    = PARALLEL * Q_WIDTH;

    typedef enum logic [1:0] {LOAD_A, LOAD_B, MAC, OUT} state_e;

    state_e                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   beat_q, beat_d;
    logic [IDX_WIDTH-1:0]   i_q, i_d;
    logic [IDX_WIDTH-1:0]   k_q, k_d;
    logic                   mode_q, mode_d;
    logic [Q_WIDTH-1:0]     acc_q [PARALLEL];
    logic [Q_WIDTH-1:0]     acc_d [PARALLEL];
    logic [Q_WIDTH-1:0]     acc_next [PARALLEL];
    logic [DW-1:0]          out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_last_q, out_last_d;
    logic                   in_ready_q, in_ready_d;
    logic                   busy_q, busy_d;

    logic [Q_WIDTH-1:0]     a_q [N];
    logic [Q_WIDTH-1:0]     b_q [N];

    logic                   in_hs;
    logic                   out_hs;

    assign in_hs  = in_valid_i & in_ready_q;
    assign out_hs = out_valid_q & out_ready_i;

    // Coefficient buffers: no reset needed, always fully rewritten before use.
    always_ff @(posedge clk_i) begin
        if (in_hs) begin
            for (int p = 0; p < int'(PARALLEL); p++) begin
                if (state_q == LOAD_A)
                    a_q[AW'(int'(beat_q) * int'(PARALLEL) + p)] <= in_data_i[p*Q_WIDTH +: Q_WIDTH];
                else
                    b_q[AW'(int'(beat_q) * int'(PARALLEL) + p)] <= in_data_i[p*Q_WIDTH +: Q_WIDTH];
            end
        end
    end

    // One MAC term per lane: coefficient c = k+p gets A[i]*B[c-i].
    // Negative c-i only contributes in negacyclic mode, wrapped and negated.
    always_comb begin : mac_terms
        int c;
        int d;
        logic [Q_WIDTH-1:0] prod;
        c    = 0;
        d    = 0;
        prod = '0;
        for (int p = 0; p < int'(PARALLEL); p++) begin
            c           = int'(k_q) + p;
            d           = c - int'(i_q);
            prod        = '0;
            acc_next[p] = acc_q[p];
            if (d >= 0 && d < int'(N)) begin
                prod        = a_q[AW'(i_q)] * b_q[AW'(d)];
                acc_next[p] = acc_q[p] + prod;
            end else if (mode_q && d < 0) begin
                prod        = a_q[AW'(i_q)] * b_q[AW'(d + int'(N))];
                acc_next[p] = acc_q[p] - prod;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin : next_state
        int l_len;
        state_d     = state_q;
        beat_d      = beat_q;
        i_d         = i_q;
        k_d         = k_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        l_len       = mode_q ? int'(N) : 2 * int'(N) - 1;

        case (state_q)
            LOAD_A: begin
                if (in_hs) begin
                    if (beat_q == '0)
                        mode_d = mode_i;
                    if (beat_q == IDX_WIDTH'(BEATS - 1)) begin
                        beat_d  = '0;
                        state_d = LOAD_B;
                    end else begin
                        beat_d = beat_q + IDX_WIDTH'(1);
                    end
                end
            end
            LOAD_B: begin
                if (in_hs) begin
                    if (beat_q == IDX_WIDTH'(BEATS - 1)) begin
                        beat_d  = '0;
                        i_d     = '0;
                        k_d     = '0;
                        for (int p = 0; p < int'(PARALLEL); p++)
                            acc_d[p] = '0;
                        state_d = MAC;
                    end else begin
                        beat_d = beat_q + IDX_WIDTH'(1);
                    end
                end
            end
            MAC: begin
                acc_d = acc_next;
                if (i_q == IDX_WIDTH'(N - 1)) begin
                    i_d         = '0;
                    state_d     = OUT;
                    out_valid_d = 1'b1;
                    out_last_d  = (int'(k_q) + int'(PARALLEL)) >= l_len;
                    // Lanes past the end of the product read as zero.
                    for (int p = 0; p < int'(PARALLEL); p++)
                        out_data_d[p*Q_WIDTH +: Q_WIDTH] =
                            ((int'(k_q) + p) < l_len) ? acc_next[p] : '0;
                end else begin
                    i_d = i_q + IDX_WIDTH'(1);
                end
            end
            OUT: begin
                if (out_hs) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        k_d     = '0;
                        state_d = LOAD_A;
                    end else begin
                        k_d     = k_q + IDX_WIDTH'(PARALLEL);
                        for (int p = 0; p < int'(PARALLEL); p++)
                            acc_d[p] = '0;
                        state_d = MAC;
                    end
                end
            end
            default: state_d = LOAD_A;
        endcase

        in_ready_d = (state_d == LOAD_A) || (state_d == LOAD_B);
        busy_d     = !((state_d == LOAD_A) && (beat_d == '0));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= LOAD_A;
            beat_q      <= '0;
            i_q         <= '0;
            k_q         <= '0;
            mode_q      <= 1'b0;
            for (int p = 0; p < int'(PARALLEL); p++)
                acc_q[p] <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            i_q         <= i_d;
            k_q         <= k_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_homomorphic_multiply_stream.sv
// Self-checking bench for homomorphic_multiply_stream (default parameters).
module tb_homomorphic_multiply_stream;

    localparam int N      = 4;
    localparam int P      = 2;
    localparam int Q      = 10;
    localparam int DW     = P * Q;
    localparam int NB_MAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    homomorphic_multiply_stream #(
        .N(4), .PARALLEL(2), .Q_WIDTH(10), .IDX_WIDTH(3)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .mode_i      (mode),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .busy_o      (busy)
    );

    typedef struct {
        logic                   m;
        logic [N*Q-1:0]         a;
        logic [N*Q-1:0]         b;
        logic [NB_MAX*DW-1:0]   exp;
        int                     nb;
    } vec_t;

    function automatic logic [4*Q-1:0] pack4(input int c0, input int c1, input int c2, input int c3);
        return {Q'(c3), Q'(c2), Q'(c1), Q'(c0)};
    endfunction

    function automatic logic [8*Q-1:0] pack8(input int c0, input int c1, input int c2, input int c3,
                                             input int c4, input int c5, input int c6, input int c7);
        return {Q'(c7), Q'(c6), Q'(c5), Q'(c4), Q'(c3), Q'(c2), Q'(c1), Q'(c0)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Send A then B; optional idle gap between beats with mode toggling.
    task automatic load(input logic m, input logic [N*Q-1:0] a, input logic [N*Q-1:0] b,
                        input int gap, input bit toggle);
        mode = m;
        for (int s = 0; s < 2; s++) begin
            for (int bt = 0; bt < N / P; bt++) begin
                logic [N*Q-1:0] v;
                v        = (s == 0) ? a : b;
                in_data  = v[bt*DW +: DW];
                in_valid = 1'b1;
                chk("in_ready_load", in_ready, 1);
                @(posedge clk); #1;
                in_valid = 1'b0;
                in_data  = '0;
                if (s == 0 && bt == 0) chk("busy_after_first", busy, 1);
                if (!(s == 1 && bt == N / P - 1)) begin
                    for (int g = 0; g < gap; g++) begin
                        if (toggle) mode = ~mode;
                        chk("in_ready_gap", in_ready, 1);
                        @(posedge clk); #1;
                    end
                end
            end
        end
    endtask

    // Receive nb beats starting right after the last B handshake.
    task automatic collect(input logic [NB_MAX*DW-1:0] exp, input int nb,
                           input int hold_beat, input bit toggle);
        for (int b = 0; b < nb; b++) begin
            int n;
            n = 0;
            do begin
                if (toggle) mode = ~mode;
                @(posedge clk); #1;
                n++;
                if (!out_valid) chk("in_ready_mac", in_ready, 0);
            end while (!out_valid && n < 40);
            chk("out_valid", out_valid, 1);
            chk("latency", n, (b == 0) ? N : N + 1);
            chk("out_data", out_data, exp[b*DW +: DW]);
            chk("out_last", out_last, (b == nb - 1) ? 1 : 0);
            chk("in_ready_out", in_ready, 0);
            if (b == hold_beat) begin
                out_ready = 1'b0;
                for (int h = 0; h < 5; h++) begin
                    @(posedge clk); #1;
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", out_data, exp[b*DW +: DW]);
                    chk("hold_last", out_last, (b == nb - 1) ? 1 : 0);
                    chk("hold_in_ready", in_ready, 0);
                end
                out_ready = 1'b1;
            end
        end
        @(posedge clk); #1;
        chk("done_valid", out_valid, 0);
        chk("done_in_ready", in_ready, 1);
        chk("done_busy", busy, 0);
    endtask

    initial begin
        vec_t vecs[5];
        logic [N*Q-1:0]       ones;
        logic [NB_MAX*DW-1:0] exp_lin_ones;

        ones         = pack4(1, 1, 1, 1);
        exp_lin_ones = pack8(1, 2, 3, 4, 3, 2, 1, 0);

        vecs[0] = '{m: 1'b0, a: ones, b: ones, exp: exp_lin_ones, nb: 4};
        vecs[1] = '{m: 1'b1, a: ones, b: ones, exp: pack8(1022, 0, 2, 4, 0, 0, 0, 0), nb: 2};
        vecs[2] = '{m: 1'b0, a: pack4(1023, 0, 0, 0), b: pack4(2, 0, 0, 0),
                    exp: pack8(1022, 0, 0, 0, 0, 0, 0, 0), nb: 4};
        vecs[3] = '{m: 1'b0, a: pack4(1, 2, 3, 4), b: pack4(5, 6, 7, 8),
                    exp: pack8(5, 16, 34, 60, 61, 52, 32, 0), nb: 4};
        vecs[4] = '{m: 1'b1, a: pack4(1, 2, 3, 4), b: pack4(5, 6, 7, 8),
                    exp: pack8(968, 988, 2, 60, 0, 0, 0, 0), nb: 2};

        rst       = 1'b1;
        mode      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven products with out_ready held high.
        for (int v = 0; v < 5; v++) begin
            load(vecs[v].m, vecs[v].a, vecs[v].b, 0, 1'b0);
            collect(vecs[v].exp, vecs[v].nb, -1, 1'b0);
        end

        // Backpressure held on the second output beat.
        load(1'b0, ones, ones, 0, 1'b0);
        collect(exp_lin_ones, 4, 1, 1'b0);

        // Input gaps with the mode pin toggling after it is latched.
        load(1'b0, ones, ones, 3, 1'b1);
        collect(exp_lin_ones, 4, -1, 1'b1);

        // Reset during the second MAC cycle abandons the product.
        load(1'b1, ones, ones, 0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        load(1'b0, ones, ones, 0, 1'b0);
        collect(exp_lin_ones, 4, -1, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
